jimmy_in_port_fifo: RTL and testbench

// Input-side buffer feeding the jimmy CPU's in_port_0. An external producer pushes bytes

---
 rtl/jimmy_io_pkg.sv | 19 +
 rtl/jimmy_strobe_edge.sv | 51 +++++
 rtl/jimmy_in_port_fifo.sv | 105 ++++++++++
 tb/tb_jimmy_in_port_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/jimmy_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jimmy_io_pkg
// Description : Shared constants and types for the jimmy CPU I/O port blocks
//               (input-side FIFO and output-side collector).
// Revision    : 1.0 - initial release
// ============================================================================
package jimmy_io_pkg;

    // Data width of the CPU I/O ports and of the producer/consumer buses.
    localparam int JIMMY_DATA_W = 8;

    // Value presented to the CPU when the input FIFO holds no data.
    localparam logic [JIMMY_DATA_W-1:0] JIMMY_IN_EMPTY = 8'h00;

    typedef logic [JIMMY_DATA_W-1:0] jimmy_byte_t;

endpackage : jimmy_io_pkg
`default_nettype wire

// File: rtl/jimmy_strobe_edge.sv
`default_nettype none
// ============================================================================
// Module      : jimmy_strobe_edge
// Description : Turns a CPU I/O strobe into a single-cycle pop request that
//               fires in the cycle after the strobe falls. A strobe must be
//               seen rising (arming) before its fall is honoured.
// Revision    : 1.0 - initial release
// ============================================================================
module jimmy_strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic pop_req
);

    logic strobe_q;
    logic armed_q;
    logic armed_d;
    logic w_rise;

    assign w_rise  = strobe & ~strobe_q;
    assign pop_req = armed_q & strobe_q & ~strobe;

    // Arm on a rising edge, disarm once the matching fall has been reported.
    always_comb begin
        armed_d = armed_q;
        if (w_rise) begin
            armed_d = 1'b1;
        end else if (pop_req) begin
            armed_d = 1'b0;
        end
    end

    // Strobe history follows the pin even through reset, so a strobe already
    // high when reset releases is not mistaken for a fresh rising edge; the
    // cleared armed flag then makes its eventual fall a no-op.
    always_ff @(posedge clk) begin
        strobe_q <= strobe;
    end

    // Armed state is cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule : jimmy_strobe_edge
`default_nettype wire

// File: rtl/jimmy_in_port_fifo.sv
`default_nettype none
// ============================================================================
// Module      : jimmy_in_port_fifo
// Description : First-word-fall-through FIFO feeding the jimmy CPU in_port_0.
//               Producer pushes with valid/ready; each CPU read strobe pops
//               the head entry one cycle after the strobe falls.
// Revision    : 1.0 - initial release
// ============================================================================
module jimmy_in_port_fifo
    import jimmy_io_pkg::*;
#(
    parameter int               WIDTH       = JIMMY_DATA_W,
    parameter int               DEPTH       = 16,
    parameter logic [WIDTH-1:0] EMPTY_VALUE = WIDTH'(JIMMY_IN_EMPTY)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   in_strobe,
    output logic [WIDTH-1:0]       in_port,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               underflow_q, underflow_d;

    logic w_pop_req;
    logic w_push;
    logic w_pop;

    jimmy_strobe_edge u_strobe_edge (
        .clk     (clk),
        .reset   (reset),
        .strobe  (in_strobe),
        .pop_req (w_pop_req)
    );

    // Status is decided purely from the registered occupancy count.
    assign empty     = (count_q == '0);
    assign full      = (count_q == c_CNT_W'(DEPTH));
    assign wr_ready  = ~full & ~reset;
    assign count     = count_q;
    assign underflow = underflow_q;
    assign in_port   = empty ? EMPTY_VALUE : mem_q[rd_ptr_q];

    assign w_push = wr_valid & wr_ready;
    assign w_pop  = w_pop_req & ~empty;

    // Next-state for pointers, occupancy and the sticky underflow flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_pop_req & empty) begin
            underflow_d = 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; contents are not reset, empty masks stale data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : jimmy_in_port_fifo
`default_nettype wire

// File: tb/tb_jimmy_in_port_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_jimmy_in_port_fifo
// Description : Directed, table-driven self-checking bench for
//               jimmy_in_port_fifo plus hand-written full/ordering sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jimmy_in_port_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       in_strobe;
    logic [7:0] in_port;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       underflow;

    int n_vec;
    int n_err;

    jimmy_in_port_fifo #(
        .WIDTH       (8),
        .DEPTH       (16),
        .EMPTY_VALUE (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .in_strobe (in_strobe),
        .in_port   (in_port),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] wd;
        logic       stb;
        logic [7:0] e_port;
        logic [4:0] e_cnt;
        logic       e_empty;
        logic       e_full;
        logic       e_rdy;
        logic       e_unf;
    } vec_t;

    vec_t vt[$];

    // Outputs sampled 1 time unit after the active edge, inputs still held.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        reset     = r;
        wr_valid  = v;
        wr_data   = d;
        in_strobe = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [7:0] p, input logic [4:0] c,
                               input logic e, input logic f, input logic r, input logic u);
        n_vec++;
        if (in_port !== p || count !== c || empty !== e || full !== f ||
            wr_ready !== r || underflow !== u) begin
            n_err++;
            $display("FAIL %s: got port=%0h cnt=%0d empty=%b full=%b rdy=%b unf=%b expected port=%0h cnt=%0d empty=%b full=%b rdy=%b unf=%b",
                     name, in_port, count, empty, full, wr_ready, underflow, p, c, e, f, r, u);
        end
    endtask

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic s, logic [7:0] p,
                                logic [4:0] c, logic e, logic f, logic rd, logic u);
        vec_t x;
        x.rst = r; x.wv = v; x.wd = d; x.stb = s;
        x.e_port = p; x.e_cnt = c; x.e_empty = e; x.e_full = f; x.e_rdy = rd; x.e_unf = u;
        return x;
    endfunction

    logic [7:0] seq2 [10];
    logic [7:0] b;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; in_strobe = 1'b0;

        // ---- table: reset, underflow, push/pop timing, strobe windows ----
        //           rst wv  wd    stb  port  cnt e f rdy unf
        vt.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0)); // reset
        vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0)); // idle empty
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0)); // strobe rise
        vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 1)); // fall -> underflow
        vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 1)); // sticky
        vt.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0)); // reset clears
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0)); // arm while empty
        vt.push_back(mk(0, 1, 8'h42, 0, 8'h42, 1, 0, 0, 1, 1)); // push + fall on empty
        vt.push_back(mk(0, 1, 8'hA5, 0, 8'h42, 2, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 8'hB6, 0, 8'h42, 3, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h42, 3, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hA5, 2, 0, 0, 1, 1)); // pop 0x42
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hA5, 2, 0, 0, 1, 1)); // 3-cycle strobe
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hA5, 2, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hA5, 2, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hB6, 1, 0, 0, 1, 1)); // single pop
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hB6, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 8'hC7, 0, 8'hB6, 2, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 8'hD8, 0, 8'hB6, 3, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hB6, 3, 0, 0, 1, 1)); // pulse 1
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hC7, 2, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'hC7, 2, 0, 0, 1, 1)); // pulse 2, 1 low gap
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hD8, 1, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 8'hD8, 1, 0, 0, 1, 1));
        for (int i = 0; i < 7; i++) begin                       // fill to 8 entries
            vt.push_back(mk(0, 1, 8'(8'h11 + i), 0, 8'hD8, 5'(2 + i), 0, 0, 1, 1));
        end
        vt.push_back(mk(1, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 0)); // reset with strobe high
        vt.push_back(mk(1, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0)); // released, strobe high
        vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0)); // fall ignored
        vt.push_back(mk(0, 1, 8'h5A, 0, 8'h5A, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 8'h5A, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0)); // normal pop again

        foreach (vt[i]) begin
            cycle(vt[i].rst, vt[i].wv, vt[i].wd, vt[i].stb);
            check_state($sformatf("vec%0d", i), vt[i].e_port, vt[i].e_cnt, vt[i].e_empty,
                        vt[i].e_full, vt[i].e_rdy, vt[i].e_unf);
        end

        // ---- full FIFO: 17th push held until a pop frees space ----
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(8'h10 + i), 0);
        check_state("full16", 8'h10, 16, 0, 1, 0, 0);
        cycle(0, 1, 8'h20, 0);
        check_state("full_hold", 8'h10, 16, 0, 1, 0, 0);
        cycle(0, 1, 8'h20, 1);
        check_state("full_strobe_hi", 8'h10, 16, 0, 1, 0, 0);
        cycle(0, 1, 8'h20, 0);
        check_state("full_pop", 8'h11, 15, 0, 0, 1, 0);
        cycle(0, 1, 8'h20, 0);
        check_state("push17", 8'h11, 16, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            b = (i == 15) ? 8'h20 : 8'(8'h11 + i);
            check($sformatf("drain%0d", i), {24'h0, in_port}, {24'h0, b});
            cycle(0, 0, 8'h00, 1);
            cycle(0, 0, 8'h00, 0);
        end
        check_state("drained", 8'h00, 0, 1, 0, 1, 0);

        // ---- ordered read-back of the sort program's input sequence ----
        seq2 = '{8'd5, 8'd3, 8'd4, 8'd5, 8'd7, 8'd2, 8'd9, 8'd6, 8'd7, 8'd4};
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, seq2[i], 0);
        check("seq_count", {27'h0, count}, 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("seq%0d", i), {24'h0, in_port}, {24'h0, seq2[i]});
            cycle(0, 0, 8'h00, 1);
            cycle(0, 0, 8'h00, 1);
            cycle(0, 0, 8'h00, 0);
        end
        check_state("seq_end", 8'h00, 0, 1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_jimmy_in_port_fifo
`default_nettype wire
